// File: rtl/mem_to_fifo.sv
// mem_to_fifo
// Replays a stored packet capture. It reads FIFO words from QDR memory, starting
// at MEM_ADDR_LOW and ending at mem_ad_end, and repeats the pass replay_cnt
// times (0 = forever). Each returned word is pushed into the replay output FIFO.
// Memory return data cannot be back-pressured, so the block limits the number
// of words requested but not yet returned to MAX_OUTSTANDING.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   sw_rst              synchronous software reset (same effect as rst)
//   cal_done            memory calibration complete; issuing pauses while low
//   start               one-cycle pulse that begins a replay (IDLE only)
//   mem_ad_end          last word address of the stored capture
//   replay_cnt          number of passes, 0 = infinite
//   busy / done         state != IDLE / one-cycle completion pulse
//   mem_r_n, mem_ad_rd  registered read command (active low) and address
//   mem_rd_full         memory read-command queue full
//   mem_qrl/qrh/qr_valid return data halves and valid (one FIFO word per cycle)
//   fifo_wr_en/data     registered FIFO write, data = {mem_qrh, mem_qrl}
//   fifo_almost_full    FIFO has only MAX_OUTSTANDING free slots left
//   state_dbg           current FSM state (IDLE=0, READ=1, DRAIN=2, DONE=3)
//
// Optional: define MEM_TO_FIFO_STATS_EN to add rd_word_cnt (FIFO words written)
// and pass_done_cnt (completed passes). Both are saturating 32-bit counters,
// cleared by reset, sw_rst and an accepted start.
//
// Handshake: a command is one cycle with mem_r_n=0; it is only decided when
// mem_rd_full is low, so every command cycle is accepted by the memory.
// Return data is accepted on every mem_qr_valid cycle with no back-pressure.
module mem_to_fifo #(
    parameter int FIFO_DATA_WIDTH  = 72,
    parameter int MEM_ADDR_WIDTH   = 19,
    parameter int MEM_DATA_WIDTH   = 36,
    parameter int MEM_BURST_LENGTH = 2,
    parameter int MEM_ADDR_LOW     = 0,
    parameter int MEM_ADDR_HIGH    = MEM_ADDR_LOW + (2**MEM_ADDR_WIDTH / MEM_BURST_LENGTH),
    parameter int MAX_OUTSTANDING  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_rst,
    input  logic                       cal_done,
    input  logic                       start,
    input  logic [MEM_ADDR_WIDTH:0]    mem_ad_end,
    input  logic [31:0]                replay_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_r_n,
    input  logic                       mem_rd_full,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_ad_rd,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_qrl,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_qrh,
    input  logic                       mem_qr_valid,
    output logic                       fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
    input  logic                       fifo_almost_full,
    output logic [1:0]                 state_dbg
`ifdef MEM_TO_FIFO_STATS_EN
    ,
    output logic [31:0]                rd_word_cnt,
    output logic [31:0]                pass_done_cnt
`endif
);

    // FIFO words returned by one read command
    localparam int HALF = MEM_BURST_LENGTH / 2;
    // wide enough to hold outstanding + HALF without overflow
    localparam int OW   = $clog2(MAX_OUTSTANDING + HALF + 1);
    localparam int AW   = MEM_ADDR_WIDTH;

    localparam logic [AW:0]   LOW_W  = (AW+1)'(MEM_ADDR_LOW);
    localparam logic [AW+1:0] HIGH_X = (AW+2)'(MEM_ADDR_HIGH);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t          state;
    logic [AW:0]     word_addr;
    logic [OW-1:0]   outstanding;
    logic [31:0]     pass_cnt;
    logic            issue_q;

    logic            can_issue;
    logic            ret_accept;
    logic            ret_dec;
    logic            end_of_pass;
    logic            last_pass;
    logic [AW+1:0]   last_word;
    logic [AW-1:0]   cmd_addr;
    logic [OW-1:0]   out_next;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        can_issue = (state == READ) && cal_done && !mem_rd_full && !fifo_almost_full
                    && ((outstanding + OW'(HALF)) <= OW'(MAX_OUTSTANDING));
        // BL4 commands occupy the bus for two cycles, so never issue back to back
        if (MEM_BURST_LENGTH == 4 && issue_q)
            can_issue = 1'b0;

        // Returns in IDLE belong to an aborted replay and are dropped
        ret_accept = mem_qr_valid && (state != IDLE);
        ret_dec    = ret_accept && (outstanding != '0);

        // Last FIFO word covered by the command at word_addr; ">=" also makes
        // an end address below MEM_ADDR_LOW behave as a single-burst capture
        last_word   = {1'b0, word_addr} + (AW+2)'(HALF - 1);
        end_of_pass = (last_word >= {1'b0, mem_ad_end}) || (last_word >= HIGH_X);
        last_pass   = (replay_cnt != 32'd0) && ((pass_cnt + 32'd1) == replay_cnt);

        cmd_addr = (MEM_BURST_LENGTH == 4) ? word_addr[AW:1] : word_addr[AW-1:0];

        out_next = outstanding;
        if (can_issue)
            out_next = out_next + OW'(HALF);
        if (ret_dec)
            out_next = out_next - OW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_r_n     <= 1'b1;
            mem_ad_rd   <= LOW_W[AW-1:0];
            fifo_wr_en  <= 1'b0;
            fifo_data   <= '0;
            word_addr   <= LOW_W;
            outstanding <= '0;
            pass_cnt    <= '0;
            issue_q     <= 1'b0;
        end else if (sw_rst) begin
            state       <= IDLE;
            mem_r_n     <= 1'b1;
            mem_ad_rd   <= LOW_W[AW-1:0];
            fifo_wr_en  <= 1'b0;
            fifo_data   <= '0;
            word_addr   <= LOW_W;
            outstanding <= '0;
            pass_cnt    <= '0;
            issue_q     <= 1'b0;
        end else begin
            mem_r_n     <= ~can_issue;
            issue_q     <= can_issue;
            outstanding <= out_next;
            if (can_issue)
                mem_ad_rd <= cmd_addr;

            fifo_wr_en <= ret_accept;
            if (ret_accept)
                fifo_data <= {mem_qrh, mem_qrl};

            case (state)
                IDLE: begin
                    if (start && cal_done) begin
                        state     <= READ;
                        word_addr <= LOW_W;
                        pass_cnt  <= '0;
                    end
                end
                READ: begin
                    if (can_issue) begin
                        if (end_of_pass) begin
                            pass_cnt  <= pass_cnt + 32'd1;
                            word_addr <= LOW_W;
                            if (last_pass)
                                state <= DRAIN;
                        end else begin
                            word_addr <= word_addr + (AW+1)'(HALF);
                        end
                    end
                end
                DRAIN: begin
                    // no commands here, so outstanding only falls
                    if (outstanding == '0)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_TO_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_cnt   <= '0;
            pass_done_cnt <= '0;
        end else if (sw_rst || (state == IDLE && start && cal_done)) begin
            rd_word_cnt   <= '0;
            pass_done_cnt <= '0;
        end else begin
            if (ret_accept && rd_word_cnt != 32'hFFFF_FFFF)
                rd_word_cnt <= rd_word_cnt + 32'd1;
            if (can_issue && end_of_pass && pass_done_cnt != 32'hFFFF_FFFF)
                pass_done_cnt <= pass_done_cnt + 32'd1;
        end
    end
`endif

endmodule
